// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    function automatic int unsigned baud_div(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the extra pointer MSB separates full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push   = wr_en_i && (!full_o || do_pop);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_sink.sv
// Oversampling UART receiver: 8 data bits, optional parity, one stop bit,
// decoded bytes buffered in a show-ahead FIFO with sticky line-error flags.
module uart_rx_sink
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 100000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int unsigned DIV   = baud_div(SYS_CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(DIV - 1);

    if (DIV < 4) begin : g_div_chk
        $error("uart_rx_sink: SYS_CLK_FREQ/BAUD_RATE must be at least 4");
    end
    if (PARITY > PAR_EVEN) begin : g_par_chk
        $error("uart_rx_sink: PARITY must be 0, 1 or 2");
    end

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             bad_q, bad_d;
    logic             fe_q, pe_q, ov_q;
    logic             tick, par_exp, push, fe_set, pe_set, ov_set;

    assign rx_s    = sync_q[1];
    assign tick    = (cnt_q == '0);
    assign par_exp = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;
    assign ov_set  = push && full && !rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            bad_q   <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            bad_q   <= bad_d;
            fe_q    <= fe_set || (fe_q && !err_clr);
            pe_q    <= pe_set || (pe_q && !err_clr);
            ov_q    <= ov_set || (ov_q && !err_clr);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        bad_d   = bad_q;
        push    = 1'b0;
        fe_set  = 1'b0;
        pe_set  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LD;
                    bad_d   = 1'b0;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        cnt_d   = FULL_LD;
                        bit_d   = '0;
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    cnt_d   = FULL_LD;
                    state_d = RX_STOP;
                    if (rx_s != par_exp) begin
                        pe_set = 1'b1;
                        bad_d  = 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        push    = !bad_q;
                        state_d = RX_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (push),
        .wr_data_i (shift_q),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx_sink.sv
// Bench for uart_rx_sink: a no-parity and an even-parity receiver checked against a queue model.
module tb_uart_rx_sink;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DIV    = 10;
    localparam int unsigned DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1, rd_en0 = 1'b0, err_clr0 = 1'b0;
    logic       rx1 = 1'b1, rd_en1 = 1'b0, err_clr1 = 1'b0;
    logic [7:0] rd_data0, rd_data1;
    logic       empty0, full0, fe0, pe0, ov0;
    logic       empty1, full1, fe1, pe1, ov1;

    always #5 clk = ~clk;

    uart_rx_sink #(
        .SYS_CLK_FREQ (CLK_HZ),
        .BAUD_RATE    (BAUD),
        .PARITY       (0),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx0),
        .rd_en      (rd_en0),
        .rd_data    (rd_data0),
        .empty      (empty0),
        .full       (full0),
        .frame_err  (fe0),
        .parity_err (pe0),
        .overrun    (ov0),
        .err_clr    (err_clr0)
    );

    uart_rx_sink #(
        .SYS_CLK_FREQ (CLK_HZ),
        .BAUD_RATE    (BAUD),
        .PARITY       (2),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut_par (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx1),
        .rd_en      (rd_en1),
        .rd_data    (rd_data1),
        .empty      (empty1),
        .full       (full1),
        .frame_err  (fe1),
        .parity_err (pe1),
        .overrun    (ov1),
        .err_clr    (err_clr1)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         fe_m[2];
    bit         pe_m[2];
    bit         ov_m[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned qsize(input int ch);
        return (ch == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qhead(input int ch);
        return (ch == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpush(input int ch, input logic [7:0] d);
        if (ch == 0) q0.push_back(d);
        else         q1.push_back(d);
    endfunction

    function automatic void qpop(input int ch);
        if (ch == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
    endfunction

    task automatic set_rx(input int ch, input logic v);
        if (ch == 0) rx0 = v;
        else         rx1 = v;
    endtask

    task automatic set_rd(input int ch, input logic v);
        if (ch == 0) rd_en0 = v;
        else         rd_en1 = v;
    endtask

    task automatic check_ch(input int ch, input string tag);
        int unsigned sz;
        sz = qsize(ch);
        if (ch == 0) begin
            check_eq({tag, "/empty"}, empty0, sz == 0);
            check_eq({tag, "/full"}, full0, sz == DEPTH);
            if (sz != 0) check_eq({tag, "/rd_data"}, rd_data0, qhead(0));
            check_eq({tag, "/frame_err"}, fe0, fe_m[0]);
            check_eq({tag, "/parity_err"}, pe0, pe_m[0]);
            check_eq({tag, "/overrun"}, ov0, ov_m[0]);
        end else begin
            check_eq({tag, "/p_empty"}, empty1, sz == 0);
            check_eq({tag, "/p_full"}, full1, sz == DEPTH);
            if (sz != 0) check_eq({tag, "/p_rd_data"}, rd_data1, qhead(1));
            check_eq({tag, "/p_frame_err"}, fe1, fe_m[1]);
            check_eq({tag, "/p_parity_err"}, pe1, pe_m[1]);
            check_eq({tag, "/p_overrun"}, ov1, ov_m[1]);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            fe_m[i] = 1'b0;
            pe_m[i] = 1'b0;
            ov_m[i] = 1'b0;
        end
    endtask

    // Start bit, 8 data bits LSB first, even parity on channel 1, stop bit, then idle.
    task automatic send_frame(input int ch, input logic [7:0] data, input bit par_good,
                              input bit stop_val, input int unsigned hold_low, input bit pop_at_stop);
        bit popped;
        popped = 1'b0;
        @(negedge clk);
        set_rx(ch, 1'b0);
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(ch, data[i]);
            repeat (DIV) @(negedge clk);
        end
        if (ch == 1) begin
            set_rx(1, (^data) ^ !par_good);
            repeat (DIV) @(negedge clk);
        end
        set_rx(ch, stop_val);
        if (pop_at_stop && qsize(ch) != 0) begin
            repeat (7) @(negedge clk);
            check_eq("pop_at_stop/head", (ch == 0) ? rd_data0 : rd_data1, qhead(ch));
            set_rd(ch, 1'b1);
            @(negedge clk);
            set_rd(ch, 1'b0);
            popped = 1'b1;
            repeat (DIV - 8) @(negedge clk);
        end else begin
            repeat (DIV) @(negedge clk);
        end
        if (!stop_val) repeat (hold_low) @(negedge clk);
        set_rx(ch, 1'b1);
        repeat (4) @(negedge clk);
        if (popped) qpop(ch);
        if (ch == 1 && !par_good) pe_m[1] = 1'b1;
        if (!stop_val) begin
            fe_m[ch] = 1'b1;
        end else if (ch == 0 || par_good) begin
            if (qsize(ch) < DEPTH) qpush(ch, data);
            else                   ov_m[ch] = 1'b1;
        end
    endtask

    task automatic pop(input int ch, input string tag);
        @(negedge clk);
        check_eq({tag, "/pop_head"}, (ch == 0) ? rd_data0 : rd_data1, qhead(ch));
        set_rd(ch, 1'b1);
        qpop(ch);
        @(negedge clk);
        set_rd(ch, 1'b0);
        check_ch(ch, tag);
    endtask

    task automatic clear_err(input int ch);
        @(negedge clk);
        if (ch == 0) err_clr0 = 1'b1;
        else         err_clr1 = 1'b1;
        @(negedge clk);
        err_clr0 = 1'b0;
        err_clr1 = 1'b0;
        fe_m[ch] = 1'b0;
        pe_m[ch] = 1'b0;
        ov_m[ch] = 1'b0;
    endtask

    initial begin
        logic [7:0] burst [6];
        logic [7:0] part;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("reset/rd_data", rd_data0, 8'h00);
        check_ch(0, "reset");
        check_ch(1, "reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(0, 8'h55, 1, 1, 0, 0);
        check_ch(0, "t1_55");
        send_frame(0, 8'hA3, 1, 1, 0, 0);
        check_ch(0, "t1_a3");
        pop(0, "t1_pop1");
        pop(0, "t1_pop2");

        @(negedge clk);
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (20) @(negedge clk);
        check_ch(0, "t2_glitch");

        send_frame(0, 8'h3C, 1, 0, 30, 0);
        check_ch(0, "t3_break");
        send_frame(0, 8'h7E, 1, 1, 0, 0);
        check_ch(0, "t3_7e");
        pop(0, "t3_pop");
        clear_err(0);
        check_ch(0, "t3_clr");

        send_frame(1, 8'h07, 0, 1, 0, 0);
        check_ch(1, "t4_badpar");
        send_frame(1, 8'h07, 1, 1, 0, 0);
        check_ch(1, "t4_goodpar");
        pop(1, "t4_pop");
        clear_err(1);
        check_ch(1, "t4_clr");

        for (int i = 0; i < 6; i++) burst[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            send_frame(0, burst[i], 1, 1, 0, 0);
            check_ch(0, "t5_fill");
        end
        clear_err(0);
        check_ch(0, "t5_clr");
        send_frame(0, burst[5], 1, 1, 0, 1);
        check_ch(0, "t5_pushpop_full");
        for (int i = 0; i < 4; i++) pop(0, "t5_drain");

        send_frame(0, 8'h5A, 1, 1, 0, 0);
        send_frame(0, 8'h81, 1, 0, 5, 0);
        send_frame(1, 8'h11, 1, 1, 0, 0);
        check_ch(0, "t6_pre");
        check_ch(1, "t6_pre");
        part = 8'hFF;
        @(negedge clk);
        rx0 = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx0 = part[i];
            repeat (DIV) @(negedge clk);
        end
        rx0 = part[4];
        repeat (DIV / 2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("t6_async/rd_data", rd_data0, 8'h00);
        check_eq("t6_async/p_rd_data", rd_data1, 8'h00);
        check_ch(0, "t6_async");
        check_ch(1, "t6_async");
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(0, 8'hC6, 1, 1, 0, 0);
        check_ch(0, "t6_after");
        pop(0, "t6_pop");

        for (int n = 0; n < 40; n++) begin
            int         ch;
            logic [7:0] d;
            bit         pg, sv, pas;
            ch  = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            pg  = (ch == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            sv  = ($urandom_range(0, 7) != 0);
            pas = ($urandom_range(0, 3) == 0);
            send_frame(ch, d, pg, sv, sv ? 0 : $urandom_range(0, 15), pas);
            check_ch(ch, "rnd_frame");
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                if (qsize(ch) != 0) pop(ch, "rnd_pop");
            end
            if ($urandom_range(0, 5) == 0) begin
                clear_err(ch);
                check_ch(ch, "rnd_clr");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_sink.md
# uart_rx_sink

Host-side UART receiver that terminates the CPU top's serial `Tx` line in simulation and on-board loopback benches. It oversamples the asynchronous line, decodes 8-bit frames (configurable parity, one stop bit), and buffers decoded bytes in a show-ahead FIFO. A consumer (testbench printer or HCI checker) drains the FIFO with a read-enable handshake. Line errors are reported as sticky flags.

## Interface
- `SYS_CLK_FREQ`, 100000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 16: receive buffer entries; power of 2, ≥2.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `rd_en`  in  1  pop the head byte; ignored when `empty`.
- `rd_data`  out  8  head byte; valid whenever `empty` = 0.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `frame_err`  out  1  sticky: stop bit sampled low.
- `parity_err`  out  1  sticky: parity mismatch.
- `overrun`  out  1  sticky: byte arrived while FIFO full.
- `err_clr`  in  1  clears all three sticky flags.

## Operation
- `DIV` = `SYS_CLK_FREQ`/`BAUD_RATE`, truncated. `DIV` < 4 is an elaboration error.
- `rx` passes through a 2-flop synchronizer (reset value 1). The FSM sees `rx_s`.
- **IDLE**: when `rx_s` = 0, load the counter with `DIV/2 - 1` and go to START.
- **START**: at terminal count, re-sample. If `rx_s` = 1, it is a glitch; return to IDLE with no flag. Otherwise load `DIV - 1`, set bit index 0, and go to DATA.
- **DATA**: at each terminal count, shift `rx_s` in, LSB first. After bit 7, go to PARITY (if `PARITY` ≠ 0) or STOP.
- **PARITY**: sample the bit and compare it with the XOR of the data, adjusted per mode. On mismatch, set `parity_err` and mark the frame bad.
- **STOP**: sample. If 1 and the frame is good, push the byte and go to IDLE. If 1 and the frame is bad, discard the byte and go to IDLE. If 0, set `frame_err`, discard the byte, and go to BREAK.
- **BREAK**: wait for `rx_s` = 1, then go to IDLE. This prevents a held-low line from generating frames.
- **FIFO**: show-ahead, `FIFO_DEPTH` entries. Pointers are `$clog2(FIFO_DEPTH)+1` bits wide; the MSB distinguishes full from empty.
- Push while full with no same-cycle pop: the byte is dropped and `overrun` is set.
- Push and pop in the same cycle while full: both take effect and the count is unchanged.
- Push and pop in the same cycle while empty: the push takes effect and the pop is ignored.
- `err_clr` in the same cycle as a new error: the error wins, and the flag stays set.

## Timing
- Reset values: FSM = IDLE, counters = 0, `rd_data` = 0, `empty` = 1, `full` = 0, all error flags = 0. The synchronizer flops reset to 1.
- Reset asserted mid-frame aborts immediately. The partial byte is lost and FIFO contents are cleared.
- Latency, start edge to START entry: 2 cycles of synchronizer delay plus 1 cycle.
- Latency, stop-bit sample to data visible: `empty` falls and `rd_data` is valid on the next clock edge.
- Pop: on the `rd_en` edge, `rd_data` advances to the next entry in the following cycle. If that pop empties the FIFO, `empty` rises in that same cycle.
- Error flags assert on the clock edge after the offending sample.
- Sampling is at mid-bit ±1 cycle. The tolerated baud mismatch is at least ±3% at `DIV` ≥ 16.

## Structure
- Shared package `uart_pkg` contains:
  - the state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the parity-mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the function `baud_div(freq, baud)`, so the future transmitter shares it.
- One sub-module, `sync_fifo`: parameterized width and depth, show-ahead, with `full` and `empty`. It is reusable by the transmitter.
- The FSM, bit counter, baud counter, and shift register live in `uart_rx_sink`.

## Test plan
All scenarios use `SYS_CLK_FREQ` = 1_000_000 and `BAUD_RATE` = 100_000, so `DIV` = 10.
1. Send 0x55, then 0xA3, with no parity → `rd_data` = 0x55 with `empty` = 0 one cycle after the stop sample. Pop, then 0xA3. All flags stay 0.
2. Release reset, then send a 4-cycle low pulse → no byte pushed, no flag set, FSM back in IDLE.
3. Send 0x3C with the stop bit driven 0, holding the line low for 30 cycles → `frame_err` = 1, FIFO stays empty. The next valid 0x7E after the line rises is received correctly.
4. With `PARITY` = 2, send 0x07 with parity bit 0 → `parity_err` = 1, byte discarded. Send 0x07 with parity bit 1 → accepted.
5. With `FIFO_DEPTH` = 4, send 5 bytes without popping → `full` = 1 after 4, `overrun` = 1, and 4 bytes are popped in order. `err_clr` then clears `overrun`.
6. Assert `rst_n` low during data bit 4 of a frame → all outputs return to their reset values asynchronously. A byte sent after reset is received intact.
